// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: word type, read_type codes and arbiter FSM/owner enums
// shared by the memory arbiter, its watchdog and the memory_pins interface.
package memory_arbiter_pkg;

    typedef logic [11:0] word_t;

    // read_type codes presented to memory_controller alongside an access
    localparam logic DATA_READ         = 1'b0;
    localparam logic INSTRUCTION_FETCH = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESPOND
    } arb_state_t;

    typedef enum logic {
        OWNER_FETCH,
        OWNER_DATA
    } arb_owner_t;

endpackage

// File: rtl/memory_pins.sv
// memory_pins: single-access memory bus between the arbiter (master) and
// memory_controller (slave). Enables are one-cycle strobes; mem_finished
// marks the cycle in which read_data is valid.
interface memory_pins;
    import memory_arbiter_pkg::*;

    word_t address;
    word_t write_data;
    word_t read_data;
    logic  read_enable;
    logic  write_enable;
    logic  mem_finished;

    modport master (
        output address, write_data, read_enable, write_enable,
        input  read_data, mem_finished
    );

    modport slave (
        input  address, write_data, read_enable, write_enable,
        output read_data, mem_finished
    );
endinterface

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: down-counter bounding how long the arbiter waits for
// mem_finished. Loaded on clear, decremented on each counted cycle; expired
// is raised during the TIMEOUT_CYCLES-th counted cycle after the load.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int            CW   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Reload on clear, count down toward terminal count while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (count_en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = count_en && (cnt == '0);

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: front end of memory_controller. Arbitrates fetch and data
// requests (data has fixed priority), runs one access at a time on the
// memory_pins master port and returns read data to the winning requester.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a watchdog that forces
// completion (rdata=0, sticky timeout_err) after TIMEOUT_CYCLES WAIT cycles.
//
//  state       | meaning
//  ARB_IDLE    | no access; pick data over fetch and latch its request
//  ARB_ISSUE   | one-cycle read or write strobe to the controller
//  ARB_WAIT    | strobes low, hold address; wait for mem_finished
//  ARB_RESPOND | one-cycle done pulse to the owner
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [11:0]        if_addr,
    output logic               if_done,
    output logic [11:0]        if_rdata,
    input  logic               dr_req,
    input  logic               dr_we,
    input  logic [11:0]        dr_addr,
    input  logic [11:0]        dr_wdata,
    output logic               dr_done,
    output logic [11:0]        dr_rdata,
    output logic               read_type,
    memory_pins.master         pins,
    output logic               busy,
    output logic               timeout_err
);

    arb_state_t state;
    arb_state_t next_state;
    arb_owner_t owner_q;
    logic       we_q;
    word_t      addr_q;
    word_t      wdata_q;
    logic       wd_expired;

    assign pins.address    = addr_q;
    assign pins.write_data = wdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
    logic wd_clear;
    logic wd_count_en;

    // Counter restarts as the access is issued, so WAIT always begins fresh
    assign wd_clear    = (state == ARB_ISSUE);
    assign wd_count_en = (state == ARB_WAIT) && !pins.mem_finished;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expired  (wd_expired)
    );
`else
    // No watchdog: WAIT exits only on mem_finished; TIMEOUT_CYCLES has no effect.
    assign wd_expired = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:    if (dr_req || if_req) next_state = ARB_ISSUE;
            ARB_ISSUE:   next_state = ARB_WAIT;
            ARB_WAIT:    if (pins.mem_finished || wd_expired) next_state = ARB_RESPOND;
            ARB_RESPOND: next_state = ARB_IDLE;
            default:     next_state = ARB_IDLE;
        endcase
    end

    // Strobes, done pulses and busy decoded from state
    always_comb begin
        pins.read_enable  = 1'b0;
        pins.write_enable = 1'b0;
        if_done           = 1'b0;
        dr_done           = 1'b0;
        busy              = (state != ARB_IDLE);
        case (state)
            ARB_ISSUE: begin
                pins.read_enable  = !we_q;
                pins.write_enable = we_q;
            end
            ARB_RESPOND: begin
                if_done = (owner_q == OWNER_FETCH);
                dr_done = (owner_q == OWNER_DATA);
            end
            default: ;
        endcase
    end

    // Request latches, returned read data and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWNER_FETCH;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            read_type   <= DATA_READ;
            if_rdata    <= '0;
            dr_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (dr_req) begin
                        owner_q   <= OWNER_DATA;
                        we_q      <= dr_we;
                        addr_q    <= dr_addr;
                        wdata_q   <= dr_wdata;
                        read_type <= DATA_READ;
                    end else if (if_req) begin
                        owner_q   <= OWNER_FETCH;
                        we_q      <= 1'b0;
                        addr_q    <= if_addr;
                        read_type <= INSTRUCTION_FETCH;
                    end
                end
                ARB_WAIT: begin
                    if (pins.mem_finished) begin
                        // A write completes without touching the owner's rdata
                        if (!we_q) begin
                            if (owner_q == OWNER_DATA) dr_rdata <= pins.read_data;
                            else                       if_rdata <= pins.read_data;
                        end
                    end else if (wd_expired) begin
                        if (owner_q == OWNER_DATA) dr_rdata <= '0;
                        else                       if_rdata <= '0;
                        timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed bench for memory_arbiter paired with a small
// behavioural memory_controller (READ/WRITE one cycle after the strobe,
// DONE the cycle after that). Octal values throughout, 12-bit words.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [11:0] if_addr = '0;
    logic        if_done;
    logic [11:0] if_rdata;
    logic        dr_req = 1'b0;
    logic        dr_we = 1'b0;
    logic [11:0] dr_addr = '0;
    logic [11:0] dr_wdata = '0;
    logic        dr_done;
    logic [11:0] dr_rdata;
    logic        read_type;
    logic        busy;
    logic        timeout_err;

    memory_pins pins();

    memory_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_done     (if_done),
        .if_rdata    (if_rdata),
        .dr_req      (dr_req),
        .dr_we       (dr_we),
        .dr_addr     (dr_addr),
        .dr_wdata    (dr_wdata),
        .dr_done     (dr_done),
        .dr_rdata    (dr_rdata),
        .read_type   (read_type),
        .pins        (pins),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory_controller; not reset by rst so abandoned accesses complete
    typedef enum logic [1:0] {C_IDLE, C_ACC, C_DONE} ctrl_t;
    ctrl_t       c_state = C_IDLE;
    logic [11:0] mem [0:4095];
    logic [11:0] c_addr = '0;
    logic [11:0] c_wdata = '0;
    logic        c_we = 1'b0;
    logic [11:0] c_rdata = '0;
    logic        ctrl_dead = 1'b0;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'o0200] = 12'o7402;
        mem[12'o0201] = 12'o5123;
        mem[12'o0100] = 12'o2222;
        mem[12'o0101] = 12'o3333;
    end

    always @(posedge clk) begin
        case (c_state)
            C_IDLE: if (pins.read_enable || pins.write_enable) begin
                c_addr  <= pins.address;
                c_wdata <= pins.write_data;
                c_we    <= pins.write_enable;
                c_state <= C_ACC;
            end
            C_ACC: if (!ctrl_dead) begin
                if (c_we) mem[c_addr] = c_wdata;
                else      c_rdata <= mem[c_addr];
                c_state <= C_DONE;
            end
            default: c_state <= C_IDLE;
        endcase
    end

    assign pins.read_data    = c_rdata;
    assign pins.mem_finished = (c_state == C_DONE);

    // Pulse counters sampled mid-cycle
    int   re_cnt = 0, we_cnt = 0, both_cnt = 0, dr_cnt = 0, if_cnt = 0;
    logic last_rt = 1'b0;
    always @(negedge clk) begin
        if (pins.read_enable) begin
            re_cnt  <= re_cnt + 1;
            last_rt <= read_type;
        end
        if (pins.write_enable) we_cnt <= we_cnt + 1;
        if (pins.read_enable && pins.write_enable) both_cnt <= both_cnt + 1;
        if (dr_done) dr_cnt <= dr_cnt + 1;
        if (if_done) if_cnt <= if_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic start_fetch(input logic [11:0] a);
        @(posedge clk); #1;
        if_addr = a;
        if_req  = 1'b1;
    endtask

    task automatic start_data(input logic we, input logic [11:0] a, input logic [11:0] wd);
        @(posedge clk); #1;
        dr_we    = we;
        dr_addr  = a;
        dr_wdata = wd;
        dr_req   = 1'b1;
    endtask

    // Bounded wait for a done pulse; returns the cycle it was seen in
    task automatic wait_done(input logic is_data, output int at_cyc);
        bit seen = 1'b0;
        at_cyc = -100;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (is_data ? dr_done : if_done) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int s, s2, at, re0, we0, dr0, if0, both0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_addr_wdata", {pins.address, pins.write_data}, 0);
        check_val("rst_strobes_dones", {pins.read_enable, pins.write_enable, if_done, dr_done}, 0);
        check_val("rst_rdata", {if_rdata, dr_rdata}, 0);
        check_val("rst_type_err", {read_type, timeout_err}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: single fetch
        re0 = re_cnt; we0 = we_cnt; dr0 = dr_cnt;
        start_fetch(12'o0200); s = cyc;
        wait_done(1'b0, at);
        check_val("t1_latency", at - s, 4);
        check_val("t1_if_rdata", if_rdata, 12'o7402);
        @(posedge clk); #1 if_req = 1'b0;
        repeat (3) @(negedge clk);
        check_val("t1_rdata_held", if_rdata, 12'o7402);
        check_val("t1_re_pulses", re_cnt - re0, 1);
        check_val("t1_we_pulses", we_cnt - we0, 0);
        check_val("t1_read_type", last_rt, INSTRUCTION_FETCH);
        check_val("t1_no_dr_done", dr_cnt - dr0, 0);
        check_val("t1_idle", busy, 0);

        // 2: write then read back
        re0 = re_cnt; we0 = we_cnt;
        start_data(1'b1, 12'o0050, 12'o1234); s = cyc;
        wait_done(1'b1, at);
        check_val("t2_wr_latency", at - s, 4);
        @(posedge clk); #1 dr_req = 1'b0;
        @(negedge clk);
        check_val("t2_we_pulses", we_cnt - we0, 1);
        check_val("t2_wr_no_re", re_cnt - re0, 0);
        check_val("t2_mem_written", mem[12'o0050], 12'o1234);
        check_val("t2_wr_keeps_rdata", dr_rdata, 0);
        start_data(1'b0, 12'o0050, 12'o0000); s = cyc;
        wait_done(1'b1, at);
        check_val("t2_rd_latency", at - s, 4);
        check_val("t2_dr_rdata", dr_rdata, 12'o1234);
        check_val("t2_read_type", last_rt, DATA_READ);
        @(posedge clk); #1 dr_req = 1'b0;

        // 3: simultaneous requests, data first
        both0 = both_cnt; if0 = if_cnt;
        @(posedge clk); #1;
        dr_we = 1'b0; dr_addr = 12'o0100; dr_req = 1'b1;
        if_addr = 12'o0101; if_req = 1'b1;
        s = cyc;
        wait_done(1'b1, at);
        check_val("t3_dr_latency", at - s, 4);
        check_val("t3_dr_rdata", dr_rdata, 12'o2222);
        check_val("t3_fetch_waits", if_cnt - if0, 0);
        @(posedge clk); #1 dr_req = 1'b0;
        wait_done(1'b0, at);
        check_val("t3_if_latency", at - s, 9);
        check_val("t3_if_rdata", if_rdata, 12'o3333);
        @(posedge clk); #1 if_req = 1'b0;
        check_val("t3_no_overlap", both_cnt - both0, 0);

        // 4: reset during WAIT
        start_data(1'b0, 12'o0100, 12'o0000); s = cyc;
        @(posedge clk); @(posedge clk); #1;
        check_val("t4_in_wait", busy, 1);
        dr0 = dr_cnt;
        rst = 1'b1; #1;
        check_val("t4_rst_busy", busy, 0);
        check_val("t4_rst_addr", pins.address, 0);
        check_val("t4_rst_dr_rdata", dr_rdata, 0);
        dr_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        check_val("t4_no_done", dr_cnt - dr0, 0);
        check_val("t4_idle", busy, 0);
        check_val("t4_stray_ignored", dr_rdata, 0);

        // 5: back-to-back fetches from a registered requester
        if0 = if_cnt; re0 = re_cnt;
        start_fetch(12'o0200); s = cyc;
        wait_done(1'b0, at);
        check_val("t5_first_latency", at - s, 4);
        @(posedge clk); #1 if_req = 1'b0;
        start_fetch(12'o0201); s2 = cyc;
        wait_done(1'b0, at);
        check_val("t5_second_latency", at - s2, 4);
        check_val("t5_if_rdata", if_rdata, 12'o5123);
        @(posedge clk); #1 if_req = 1'b0;
        repeat (3) @(negedge clk);
        check_val("t5_done_count", if_cnt - if0, 2);
        check_val("t5_re_count", re_cnt - re0, 2);
        start_data(1'b0, 12'o0050, 12'o0000);
        wait_done(1'b1, at);
        check_val("t5_data_read", dr_rdata, 12'o1234);
        @(posedge clk); #1 dr_req = 1'b0;
        check_val("t5_no_timeout_err", timeout_err, 0);

        // 6: controller never finishes
        ctrl_dead = 1'b1;
        dr0 = dr_cnt;
        start_data(1'b0, 12'o0050, 12'o0000); s = cyc;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_done(1'b1, at);
        check_val("t6_timeout_latency", at - s, 6);
        check_val("t6_rdata_zeroed", dr_rdata, 0);
        check_val("t6_timeout_err", timeout_err, 1);
        @(posedge clk); #1 dr_req = 1'b0;
        repeat (5) @(negedge clk);
        check_val("t6_err_sticky", timeout_err, 1);
        check_val("t6_idle", busy, 0);
`else
        repeat (20) @(negedge clk);
        check_val("t6_still_busy", busy, 1);
        check_val("t6_no_done", dr_cnt - dr0, 0);
        check_val("t6_no_timeout_err", timeout_err, 0);
        dr_req = 1'b0;
`endif
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_clears_err", {busy, timeout_err}, 0);
        ctrl_dead = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
